// File: rtl/ppu_dma_pkg.sv
// rtl/ppu_dma_pkg.sv - shared types and constants for the PPU SDRAM-to-VRAM DMA
//
// Purpose: state encoding and bus widths used by ppu_sdram_dma and ppu_dma_beat_packer.
// Ports:   none (package).
package ppu_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_DONE      = 2'd3
    } dma_state_t;

    localparam int BURST_MAX_DEFAULT = 64;   // beats per Avalon burst
    localparam int BC_W              = 8;    // Avalon burstcount width
    localparam int BEAT_W            = 64;   // f2h_sdram0 data width
    localparam int WORD_W            = 128;  // VRAM word width (two beats)

endpackage

// File: rtl/ppu_dma_beat_packer.sv
// rtl/ppu_dma_beat_packer.sv - pairs 64-bit SDRAM beats into 128-bit VRAM words
//
// Purpose: even beat is held in a pairing register; the odd beat completes the word and
//          raises o_wren for one cycle with o_wrdata = {odd, even}.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_clear          re-align the even/odd toggle (new transfer)
//   i_valid, i_data  beat to pack
//   o_wren           one-cycle VRAM write strobe
//   o_wrdata         {odd beat, even beat}
module ppu_dma_beat_packer
    import ppu_dma_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [BEAT_W-1:0] i_data,
    output logic              o_wren,
    output logic [WORD_W-1:0] o_wrdata
);

    logic              r_odd;
    logic [BEAT_W-1:0] r_even;
    logic              r_wren;
    logic [WORD_W-1:0] r_wrdata;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_odd    <= 1'b0;
            r_even   <= '0;
            r_wren   <= 1'b0;
            r_wrdata <= '0;
        end else begin
            r_wren <= 1'b0;
            if (i_clear) begin
                r_odd <= 1'b0;
            end else if (i_valid) begin
                if (r_odd) begin
                    r_wrdata <= {i_data, r_even};
                    r_wren   <= 1'b1;
                    r_odd    <= 1'b0;
                end else begin
                    r_even <= i_data;
                    r_odd  <= 1'b1;
                end
            end
        end
    end

    assign o_wren   = r_wren;
    assign o_wrdata = r_wrdata;

endmodule

// File: rtl/ppu_sdram_dma.sv
// rtl/ppu_sdram_dma.sv - Avalon-MM burst-read DMA copying an SDRAM image into PPU VRAM
//
// Purpose: issues one outstanding burst at a time on f2h_sdram0, packs beat pairs into
//          128-bit VRAM writes and pulses o_done_irq when the last word is written.
// Optional feature macro: PPU_SDRAM_DMA_ABORT_EN adds i_abort / o_aborted.
// Ports:
//   i_clk, i_reset                     clock, synchronous active-high reset
//   i_start                            1-cycle start pulse, ignored unless idle
//   i_src_base / i_vram_base           SDRAM (64-bit words) / VRAM (128-bit words) start
//   i_xfer_len                         length in 128-bit words (0..2^VRAM_AW)
//   i_abort / o_aborted                abort pulse / sticky abort flag (macro only)
//   o_sdram_address/burstcount/read    Avalon read command
//   i_sdram_waitrequest                Avalon stall
//   i_sdram_readdata/readdatavalid     Avalon read beats
//   o_vram_wraddr/wren/wrdata          VRAM write port
//   o_busy, o_done_irq                 status
module ppu_sdram_dma
    import ppu_dma_pkg::*;
#(
    parameter int SDRAM_AW  = 29,
    parameter int BURST_MAX = BURST_MAX_DEFAULT,
    parameter int VRAM_AW   = 12
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [SDRAM_AW-1:0] i_src_base,
    input  logic [VRAM_AW-1:0]  i_vram_base,
    input  logic [VRAM_AW:0]    i_xfer_len,
`ifdef PPU_SDRAM_DMA_ABORT_EN
    input  logic                i_abort,
    output logic                o_aborted,
`endif
    output logic [SDRAM_AW-1:0] o_sdram_address,
    output logic [BC_W-1:0]     o_sdram_burstcount,
    output logic                o_sdram_read,
    input  logic                i_sdram_waitrequest,
    input  logic [BEAT_W-1:0]   i_sdram_readdata,
    input  logic                i_sdram_readdatavalid,
    output logic [VRAM_AW-1:0]  o_vram_wraddr,
    output logic                o_vram_wren,
    output logic [WORD_W-1:0]   o_vram_wrdata,
    output logic                o_busy,
    output logic                o_done_irq
);

    // Two beats per word, so the beat budget needs one more bit than xfer_len.
    localparam int BL_W = VRAM_AW + 2;

    dma_state_t          r_state;
    dma_state_t          w_next;
    logic [SDRAM_AW-1:0] r_addr;
    logic [BC_W-1:0]     r_bc;
    logic [BC_W-1:0]     r_burst_rem;
    logic [BC_W-1:0]     w_bc_next;
    logic [BL_W-1:0]     r_beats_left;   // beats not yet requested
    logic [BL_W-1:0]     w_bc_src;
    logic [VRAM_AW-1:0]  r_wraddr;
    logic                r_busy;
    logic                r_done_irq;
    logic                r_abort_flag;
    logic                w_start_ok;
    logic                w_accept;
    logic                w_beat;
    logic                w_burst_end;
    logic                w_abort;
    logic                w_pack_valid;
    logic                w_pack_wren;

`ifdef PPU_SDRAM_DMA_ABORT_EN
    assign w_abort = i_abort & ((r_state == ST_REQ) | (r_state == ST_WAIT_DATA));
`else
    assign w_abort = 1'b0;
`endif

    assign w_start_ok  = (r_state == ST_IDLE) & i_start;
    assign w_accept    = (r_state == ST_REQ) & ~i_sdram_waitrequest;
    assign w_beat      = (r_state == ST_WAIT_DATA) & i_sdram_readdatavalid;
    assign w_burst_end = w_beat & (r_burst_rem == BC_W'(1));

    // Once aborted, beats are still counted (drained) but never reach VRAM.
    assign w_pack_valid = w_beat & ~r_abort_flag & ~w_abort;

    // Next burst length: at start from the fresh length, afterwards from what is left.
    assign w_bc_src  = w_start_ok ? {i_xfer_len, 1'b0} : r_beats_left;
    assign w_bc_next = (w_bc_src > BL_W'(BURST_MAX)) ? BC_W'(BURST_MAX) : BC_W'(w_bc_src);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_sdram_read = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next = (i_xfer_len == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                o_sdram_read = 1'b1;
                // An accepted request must be drained even if abort arrives with it.
                if (w_accept) begin
                    w_next = ST_WAIT_DATA;
                end else if (w_abort) begin
                    w_next = ST_DONE;
                end
            end
            ST_WAIT_DATA: begin
                if (w_burst_end) begin
                    w_next = ((r_beats_left != '0) && !r_abort_flag && !w_abort) ? ST_REQ : ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr       <= '0;
            r_bc         <= '0;
            r_burst_rem  <= '0;
            r_beats_left <= '0;
            r_wraddr     <= '0;
            r_busy       <= 1'b0;
            r_done_irq   <= 1'b0;
            r_abort_flag <= 1'b0;
        end else begin
            r_done_irq <= 1'b0;

            if (w_start_ok) begin
                r_addr       <= i_src_base;
                r_wraddr     <= i_vram_base;
                r_beats_left <= {i_xfer_len, 1'b0};
                r_bc         <= w_bc_next;
                r_busy       <= 1'b1;
                r_abort_flag <= 1'b0;
            end

            if (w_abort) begin
                r_abort_flag <= 1'b1;
            end

            if (w_accept) begin
                r_beats_left <= r_beats_left - BL_W'(r_bc);
                r_burst_rem  <= r_bc;
            end

            if (w_beat) begin
                r_burst_rem <= r_burst_rem - BC_W'(1);
            end

            // Address advance wraps naturally at 2^SDRAM_AW.
            if (w_burst_end && (r_beats_left != '0)) begin
                r_addr <= r_addr + SDRAM_AW'(r_bc);
                r_bc   <= w_bc_next;
            end

            if (w_pack_wren) begin
                r_wraddr <= r_wraddr + VRAM_AW'(1);
            end

            if (r_state == ST_DONE) begin
                r_done_irq <= 1'b1;
                r_busy     <= 1'b0;
            end
        end
    end

`ifdef PPU_SDRAM_DMA_ABORT_EN
    logic r_aborted;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_aborted <= 1'b0;
        end else if (w_start_ok) begin
            r_aborted <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_aborted <= r_abort_flag;
        end
    end

    assign o_aborted = r_aborted;
`endif

    ppu_dma_beat_packer u_packer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_start_ok),
        .i_valid  (w_pack_valid),
        .i_data   (i_sdram_readdata),
        .o_wren   (w_pack_wren),
        .o_wrdata (o_vram_wrdata)
    );

    assign o_sdram_address    = r_addr;
    assign o_sdram_burstcount = r_bc;
    assign o_vram_wraddr      = r_wraddr;
    assign o_vram_wren        = w_pack_wren;
    assign o_busy             = r_busy;
    assign o_done_irq         = r_done_irq;

endmodule

// File: tb/tb_ppu_sdram_dma.sv
// tb/tb_ppu_sdram_dma.sv - randomized self-checking bench for ppu_sdram_dma
module tb_ppu_sdram_dma;

    localparam int SAW  = 29;
    localparam int VAW  = 12;
    localparam int BMAX = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset     = 1'b1;
    logic           start     = 1'b0;
    logic [SAW-1:0] src_base  = '0;
    logic [VAW-1:0] vram_base = '0;
    logic [VAW:0]   xfer_len  = '0;
    logic           waitreq   = 1'b0;
    logic           rdv       = 1'b0;
    logic [63:0]    rdata     = '0;
    logic [SAW-1:0] sd_addr;
    logic [7:0]     sd_bc;
    logic           sd_read;
    logic [VAW-1:0] wraddr;
    logic           wren;
    logic [127:0]   wrdata;
    logic           busy;
    logic           done_irq;
`ifdef PPU_SDRAM_DMA_ABORT_EN
    logic           abort = 1'b0;
    logic           aborted;
`endif

    ppu_sdram_dma dut (
        .i_clk                 (clk),
        .i_reset               (reset),
        .i_start               (start),
        .i_src_base            (src_base),
        .i_vram_base           (vram_base),
        .i_xfer_len            (xfer_len),
`ifdef PPU_SDRAM_DMA_ABORT_EN
        .i_abort               (abort),
        .o_aborted             (aborted),
`endif
        .o_sdram_address       (sd_addr),
        .o_sdram_burstcount    (sd_bc),
        .o_sdram_read          (sd_read),
        .i_sdram_waitrequest   (waitreq),
        .i_sdram_readdata      (rdata),
        .i_sdram_readdatavalid (rdv),
        .o_vram_wraddr         (wraddr),
        .o_vram_wren           (wren),
        .o_vram_wrdata         (wrdata),
        .o_busy                (busy),
        .o_done_irq            (done_irq)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // SDRAM contents as a pure function of the 64-bit word address.
    function automatic logic [63:0] mem(input logic [SAW-1:0] a);
        logic [31:0] x;
        x = 32'(a);
        return {x ^ 32'hDEAD_0000, x * 32'd3 + 32'd1};
    endfunction

    typedef struct { logic [SAW-1:0] a; logic [7:0] bc; } burst_t;
    typedef struct { logic [VAW-1:0] a; logic [127:0] d; } wr_t;

    burst_t exp_b[$];
    burst_t got_b[$];
    wr_t    exp_w[$];
    wr_t    got_w[$];

    bit             active    = 0;
    bit             aborting  = 0;
    bit             exp_len0  = 0;
    int             cyc       = 0;
    int             start_cyc = 0;
    int             pending   = 0;
    logic [SAW-1:0] beat_addr = '0;
    int             wait_left = 0;
    int             wait_plan[$];
    bit             prev_stall = 0;
    logic [SAW-1:0] prev_addr  = '0;
    logic [7:0]     prev_bc    = '0;
    int             gap_pct    = 0;
    int             spur_pct   = 20;

    bit             go        = 0;
    bit             go_model  = 0;
    bit             rst_req   = 0;
    bit             abort_req = 0;
    logic [SAW-1:0] go_src    = '0;
    logic [VAW-1:0] go_vb     = '0;
    logic [VAW:0]   go_len    = '0;

    // Expected bursts and writes of a whole transfer, straight from its definition.
    task automatic plan(input logic [SAW-1:0] s, input logic [VAW-1:0] v, input logic [VAW:0] len);
        int             beats;
        logic [SAW-1:0] a;
        beats = 2 * int'(len);
        a     = s;
        exp_b.delete(); exp_w.delete(); got_b.delete(); got_w.delete();
        while (beats > 0) begin
            burst_t b;
            b.a  = a;
            b.bc = 8'((beats > BMAX) ? BMAX : beats);
            exp_b.push_back(b);
            a     = a + SAW'(b.bc);
            beats = beats - int'(b.bc);
        end
        for (int k = 0; k < int'(len); k++) begin
            wr_t            w;
            logic [SAW-1:0] e;
            e   = s + SAW'(2 * k);
            w.a = v + VAW'(k);
            w.d = {mem(e + SAW'(1)), mem(e)};
            exp_w.push_back(w);
        end
    endtask

    // One clock: observe outputs at the falling edge, then drive inputs for the next rise.
    task automatic step();
        @(negedge clk);
        cyc++;

        if (wren) begin
            wr_t g;
            g.a = wraddr;
            g.d = wrdata;
            got_w.push_back(g);
            if (aborting || exp_w.size() == 0) begin
                fail("unexpected_wren", 128'(wraddr), 0);
            end else begin
                wr_t e;
                e = exp_w.pop_front();
                chk("wraddr", 128'(wraddr), 128'(e.a));
                chk("wrdata", wrdata, e.d);
            end
        end

        if (done_irq) begin
            if (!active) begin
                fail("spurious_done_irq", 1, 0);
            end else begin
                active = 0;
                if (exp_len0) chk("len0_done_latency", 128'(cyc - start_cyc), 2);
                if (!aborting) begin
                    chk("writes_left_at_done", 128'(exp_w.size()), 0);
                    chk("bursts_left_at_done", 128'(exp_b.size()), 0);
                end
`ifdef PPU_SDRAM_DMA_ABORT_EN
                chk("aborted_with_done", 128'(aborted), 128'(aborting));
`endif
            end
        end
        chk("busy", 128'(busy), 128'(active));

        if (prev_stall) begin
            chk("read_held", 128'(sd_read), 1);
            chk("addr_held", 128'(sd_addr), 128'(prev_addr));
            chk("bc_held", 128'(sd_bc), 128'(prev_bc));
        end

        // Beats for bursts accepted on earlier edges; stray valids otherwise.
        rdv   = 1'b0;
        rdata = '0;
        if (!rst_req) begin
            if (pending > 0) begin
                if (int'($urandom_range(99)) >= gap_pct) begin
                    rdv       = 1'b1;
                    rdata     = mem(beat_addr);
                    beat_addr = beat_addr + SAW'(1);
                    pending--;
                end
            end else if (int'($urandom_range(99)) < spur_pct) begin
                rdv   = 1'b1;
                rdata = {$urandom, $urandom};
            end
        end

        waitreq = 1'b0;
        if (sd_read && !rst_req) begin
            if (!prev_stall) wait_left = (wait_plan.size() > 0) ? wait_plan.pop_front() : int'($urandom_range(2));
            if (wait_left > 0) begin
                waitreq = 1'b1;
                wait_left--;
            end
        end
        prev_stall = sd_read && waitreq && !rst_req;
        prev_addr  = sd_addr;
        prev_bc    = sd_bc;

        if (sd_read && !waitreq && !rst_req) begin
            burst_t g;
            g.a  = sd_addr;
            g.bc = sd_bc;
            got_b.push_back(g);
            chk("one_outstanding", 128'(pending), 0);
            if (exp_b.size() == 0) begin
                fail("unexpected_read", 128'(sd_addr), 0);
            end else begin
                burst_t e;
                e = exp_b.pop_front();
                chk("burst_addr", 128'(sd_addr), 128'(e.a));
                chk("burst_bc", 128'(sd_bc), 128'(e.bc));
            end
            pending   = int'(sd_bc);
            beat_addr = sd_addr;
        end

        reset = rst_req;
        if (rst_req) begin
            pending    = 0;
            active     = 0;
            aborting   = 0;
            prev_stall = 0;
            exp_b.delete();
            exp_w.delete();
        end

`ifdef PPU_SDRAM_DMA_ABORT_EN
        abort = abort_req;
        if (abort_req) begin
            prev_stall = 0;
            if (active) begin
                aborting = 1;
                exp_b.delete();
            end
        end
        abort_req = 0;
`endif

        start = go;
        if (go) begin
            src_base  = go_src;
            vram_base = go_vb;
            xfer_len  = go_len;
            if (go_model) begin
                plan(go_src, go_vb, go_len);
                active    = 1;
                aborting  = 0;
                exp_len0  = (go_len == '0);
                start_cyc = cyc;
            end
            go = 0;
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (active && n < budget) begin
            step();
            n++;
        end
        if (active) begin
            fail("done_timeout", 0, 1);
            active = 0;
        end
    endtask

    task automatic launch(input logic [SAW-1:0] s, input logic [VAW-1:0] v, input logic [VAW:0] len);
        go       = 1;
        go_model = 1;
        go_src   = s;
        go_vb    = v;
        go_len   = len;
        step();
    endtask

    task automatic xfer(input logic [SAW-1:0] s, input logic [VAW-1:0] v, input logic [VAW:0] len);
        launch(s, v, len);
        wait_done(20000);
        step();
        step();
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k;
        k = 0;
        while (got_w.size() < n && k < budget) begin
            step();
            k++;
        end
        if (got_w.size() < n) fail("write_timeout", 128'(got_w.size()), 128'(n));
    endtask

    initial begin
        rst_req = 1;
        repeat (3) step();
        rst_req = 0;
        step();
        chk("rst_read", 128'(sd_read), 0);
        chk("rst_addr", 128'(sd_addr), 0);
        chk("rst_bc", 128'(sd_bc), 0);
        chk("rst_wren", 128'(wren), 0);
        chk("rst_wraddr", 128'(wraddr), 0);
        chk("rst_wrdata", wrdata, 0);
        chk("rst_done", 128'(done_irq), 0);

        // Single word.
        xfer(29'h100, 12'h000, 13'd1);
        chk("t1_nbursts", 128'(got_b.size()), 1);
        chk("t1_addr", 128'(got_b[0].a), 128'h100);
        chk("t1_bc", 128'(got_b[0].bc), 2);
        chk("t1_nwrites", 128'(got_w.size()), 1);
        chk("t1_wraddr", 128'(got_w[0].a), 0);
        chk("t1_wrdata", got_w[0].d, 128'hDEAD0101_00000304_DEAD0100_00000301);

        // Two bursts, second one stalled for 5 cycles.
        wait_plan = {0, 5};
        xfer(29'h0, 12'h000, 13'd40);
        chk("t2_nbursts", 128'(got_b.size()), 2);
        chk("t2_b0_addr", 128'(got_b[0].a), 128'h0);
        chk("t2_b0_bc", 128'(got_b[0].bc), 64);
        chk("t2_b1_addr", 128'(got_b[1].a), 128'h40);
        chk("t2_b1_bc", 128'(got_b[1].bc), 16);
        chk("t2_nwrites", 128'(got_w.size()), 40);
        chk("t2_last_wraddr", 128'(got_w[39].a), 39);

        // Zero length, with a start while busy that must be ignored.
        launch(29'h777, 12'h010, 13'd0);
        go       = 1;
        go_model = 0;
        go_src   = 29'h55;
        go_vb    = 12'h020;
        go_len   = 13'd5;
        step();
        wait_done(10);
        repeat (10) step();
        chk("t4_no_read", 128'(got_b.size()), 0);
        chk("t4_no_write", 128'(got_w.size()), 0);

        // Address wrap on both sides.
        xfer(29'h1FFF_FFFE, 12'hFFF, 13'd2);
        chk("t5_addr", 128'(got_b[0].a), 128'h1FFF_FFFE);
        chk("t5_bc", 128'(got_b[0].bc), 4);
        chk("t5_w0", 128'(got_w[0].a), 128'hFFF);
        chk("t5_w1", 128'(got_w[1].a), 0);

        // Reset in the middle of a burst.
        launch(29'h1234, 12'h100, 13'd20);
        wait_writes(2, 2000);
        rst_req = 1;
        step();
        rst_req = 0;
        step();
        chk("t6_read", 128'(sd_read), 0);
        chk("t6_wren", 128'(wren), 0);
        chk("t6_busy", 128'(busy), 0);
        chk("t6_done", 128'(done_irq), 0);
        chk("t6_addr", 128'(sd_addr), 0);
        chk("t6_wraddr", 128'(wraddr), 0);
        repeat (20) step();

`ifdef PPU_SDRAM_DMA_ABORT_EN
        launch(29'h2000, 12'h000, 13'd64);
        wait_writes(3, 2000);
        abort_req = 1;
        step();
        wait_done(2000);
        step();
        chk("ab_nbursts", 128'(got_b.size()), 1);
        chk("ab_aborted_held", 128'(aborted), 1);
        xfer(29'h3000, 12'h200, 13'd3);
`endif

        // Randomized transfers, then the maximum length.
        for (int i = 0; i < 10; i++) begin
            gap_pct = int'($urandom_range(40));
            xfer(SAW'($urandom), VAW'($urandom), (VAW+1)'($urandom_range(1, 150)));
        end
        gap_pct = 0;
        xfer(SAW'($urandom), VAW'($urandom), 13'd4096);
        chk("max_nbursts", 128'(got_b.size()), 128);
        chk("max_nwrites", 128'(got_w.size()), 4096);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
